// File: rtl/track_loop_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// track_loop_arbiter_pkg
//   Shared definitions for the multi-channel tracking-loop arbiter:
//   default sizes, channel-index width derivation, arbiter state encoding
//   and the field layout of the request (history) and result records.
//   The correlator channels pack and unpack with the same field ranges.
// -----------------------------------------------------------------------------
package track_loop_arbiter_pkg;

    localparam int NUM_CH_DEFAULT = 4;
    localparam int REQ_W_DEFAULT  = 128;
    localparam int RES_W_DEFAULT  = 96;

    // Channel index width; a single bit is kept even for tiny channel counts.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_START = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_e;

    // Request record: per-dump history of one channel.
    localparam int REQ_I2Q2_E_LSB   = 0;    localparam int REQ_I2Q2_E_W   = 16;
    localparam int REQ_I2Q2_P_LSB   = 16;   localparam int REQ_I2Q2_P_W   = 16;
    localparam int REQ_I2Q2_L_LSB   = 32;   localparam int REQ_I2Q2_L_W   = 16;
    localparam int REQ_IQ_KM1_LSB   = 48;   localparam int REQ_IQ_KM1_W   = 32;
    localparam int REQ_W_DF_LSB     = 80;   localparam int REQ_W_DF_W     = 24;
    localparam int REQ_W_DF_DOT_LSB = 104;  localparam int REQ_W_DF_DOT_W = 24;

    // Result record: loop update returned to the channel.
    localparam int RES_IQ_PROMPT_LSB   = 0;   localparam int RES_IQ_PROMPT_W   = 32;
    localparam int RES_DOPPLER_INC_LSB = 32;  localparam int RES_DOPPLER_INC_W = 16;
    localparam int RES_W_DF_LSB        = 48;  localparam int RES_W_DF_W        = 16;
    localparam int RES_W_DF_DOT_LSB    = 64;  localparam int RES_W_DF_DOT_W    = 16;
    localparam int RES_CA_DPHI_LSB     = 80;  localparam int RES_CA_DPHI_W     = 16;

endpackage

// File: rtl/track_loop_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector: returns the first set bit of
//   'pending' at or after index 'rr', searching cyclically.
// Ports:
//   pending   in  NUM_CH  request vector
//   rr        in  CH_W    highest-priority index
//   sel       out CH_W    selected index (0 when nothing pending)
//   any_valid out 1       at least one pending bit set
// -----------------------------------------------------------------------------
module rr_pick
    import track_loop_arbiter_pkg::*;
#(
    parameter  int NUM_CH = NUM_CH_DEFAULT,
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [CH_W-1:0]   rr,
    output logic [CH_W-1:0]   sel,
    output logic              any_valid
);

    int idx;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    // NOTE: blocking assignments here: later iterations must see earlier results.
    always_comb begin
        sel       = '0;
        any_valid = 1'b0;
        idx       = 0;
        // Walk from the lowest priority upward so the last hit is the winner.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = (int'(rr) + i) % NUM_CH;
            if (pending[idx]) begin
                sel       = CH_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/track_loop_arbiter.sv
// -----------------------------------------------------------------------------
// track_loop_arbiter
//   Shares one tracking-loop datapath among NUM_CH correlator channels.
//   Each channel strobes a history record into its buffer; the arbiter
//   serves buffered channels round-robin: issue record, wait for the loop
//   result, return it to the originating channel.
// Optional feature: define TRACK_LOOP_ARBITER_TIMEOUT_EN to add a WAIT
//   watchdog (TIMEOUT_CYCLES) and the 'timeout' pulse output.
// Ports:
//   clk, global_reset_n    clock, async active-low reset
//   req_valid/req_data     per-channel record strobes and records
//   req_pending            channel has a buffered, unissued record
//   loop_start/data/ch     one-cycle start, record and channel to the loop
//   loop_ready/result      result strobe and value from the loop
//   res_valid/res_data     one-hot result strobe, broadcast result
//   overflow               sticky: record replaced before being issued
//   busy                   arbiter not idle
//   timeout                (optional) one-cycle watchdog pulse
// -----------------------------------------------------------------------------
module track_loop_arbiter
    import track_loop_arbiter_pkg::*;
#(
    parameter  int NUM_CH = NUM_CH_DEFAULT,
    parameter  int REQ_W  = REQ_W_DEFAULT,
    parameter  int RES_W  = RES_W_DEFAULT,
`ifdef TRACK_LOOP_ARBITER_TIMEOUT_EN
    parameter  int TIMEOUT_CYCLES = 1024,
`endif
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    global_reset_n,
    input  logic [NUM_CH-1:0]       req_valid,
    input  logic [NUM_CH*REQ_W-1:0] req_data,
    output logic [NUM_CH-1:0]       req_pending,
    output logic                    loop_start,
    output logic [REQ_W-1:0]        loop_data,
    output logic [CH_W-1:0]         loop_ch,
    input  logic                    loop_ready,
    input  logic [RES_W-1:0]        loop_result,
    output logic [NUM_CH-1:0]       res_valid,
    output logic [RES_W-1:0]        res_data,
`ifdef TRACK_LOOP_ARBITER_TIMEOUT_EN
    output logic                    timeout,
`endif
    output logic [NUM_CH-1:0]       overflow,
    output logic                    busy
);

    arb_state_e        state, state_nxt;
    logic [NUM_CH-1:0] pending_q;
    logic [REQ_W-1:0]  rec_buf [NUM_CH];
    logic [CH_W-1:0]   rr_q;
    logic [CH_W-1:0]   sel;
    logic              any_pending;
    logic              grant;
    logic              retire;
    logic [CH_W-1:0]   rr_after;

    rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
        .pending   (pending_q),
        .rr        (rr_q),
        .sel       (sel),
        .any_valid (any_pending)
    );

    assign req_pending = pending_q;
    assign grant       = (state == ARB_IDLE) && any_pending;
    assign rr_after    = (loop_ch == CH_W'(NUM_CH - 1)) ? '0 : loop_ch + 1'b1;

`ifdef TRACK_LOOP_ARBITER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] wait_cnt;
    logic            wait_expired;

    // Last WAIT cycle with no result: give up on this transaction.
    assign wait_expired = (state == ARB_WAIT) && !loop_ready &&
                          (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= wait_expired;
            if (state == ARB_START)
                wait_cnt <= '0;
            else if (state == ARB_WAIT)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end
`endif

    // A transaction retires on DONE, or when the watchdog abandons it;
    // either way the served channel drops to lowest priority.
    assign retire = (state == ARB_DONE)
`ifdef TRACK_LOOP_ARBITER_TIMEOUT_EN
                    || wait_expired
`endif
                    ;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) state <= ARB_IDLE;
        else                 state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ARB_IDLE:  if (any_pending) state_nxt = ARB_START;
            ARB_START: state_nxt = ARB_WAIT;
            ARB_WAIT: begin
                if (loop_ready) state_nxt = ARB_DONE;
`ifdef TRACK_LOOP_ARBITER_TIMEOUT_EN
                else if (wait_expired) state_nxt = ARB_IDLE;
`endif
            end
            ARB_DONE:  state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        loop_start = (state == ARB_START);
        busy       = (state != ARB_IDLE);
        res_valid  = '0;
        if (state == ARB_DONE) res_valid[loop_ch] = 1'b1;
    end

    // NOTE: record buffers are reset so a stale record can never reach the loop.
    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            pending_q <= '0;
            overflow  <= '0;
            loop_data <= '0;
            loop_ch   <= '0;
            res_data  <= '0;
            rr_q      <= '0;
            for (int c = 0; c < NUM_CH; c++) rec_buf[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (req_valid[c]) begin
                    rec_buf[c]   <= req_data[c*REQ_W +: REQ_W];
                    pending_q[c] <= 1'b1;
                    // Replacing an unissued record loses data; a record taken
                    // by the select in this same cycle is not lost.
                    if (pending_q[c] && !(grant && sel == CH_W'(c)))
                        overflow[c] <= 1'b1;
                end else if (grant && sel == CH_W'(c)) begin
                    pending_q[c] <= 1'b0;
                end
            end
            if (grant) begin
                loop_data <= rec_buf[sel];
                loop_ch   <= sel;
            end
            if (state == ARB_WAIT && loop_ready) res_data <= loop_result;
            if (retire) rr_q <= rr_after;
        end
    end

endmodule
